// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/status and datapath-control bundle of the ALU sequencer
interface alu_seq_ctrl_if;
    logic       start;
    logic [4:0] opcode;
    logic       busy;
    logic       done;
    logic       err;
    logic       Ra_out;
    logic       Yin;
    logic       Rb_out;
    logic [4:0] alu_op;
    logic       Zin;
    logic       Zlo_out;
    logic       Zhi_out;
    logic       Rd_in;
    logic       LOin;
    logic       HIin;
    modport master (
        output start, opcode,
        input  busy, done, err, Ra_out, Yin, Rb_out, alu_op, Zin, Zlo_out, Zhi_out, Rd_in, LOin, HIin
    );
    modport slave (
        input  start, opcode,
        output busy, done, err, Ra_out, Yin, Rb_out, alu_op, Zin, Zlo_out, Zhi_out, Rd_in, LOin, HIin
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: single-bus ALU sequencer, LOADA/EXEC/writeback with multi-cycle mul/div
module alu_seq_ctrl #(
    parameter int wordSize   = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input logic         clk,
    input logic         clr,
    alu_seq_ctrl_if.slave bus
);
    if (wordSize < 1) $error("wordSize must be positive");
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) $error("MUL_CYCLES out of range 1-15");
    if (DIV_CYCLES < 1 || DIV_CYCLES > 15) $error("DIV_CYCLES out of range 1-15");
    typedef enum logic [2:0] {IDLE, LOADA, EXEC, WB_LO, WB_HI, DONE} state_t;
    state_t     state, state_n;
    logic [4:0] op_q, op_n;
    logic [3:0] cnt, cnt_n;
    logic       md;
    assign md = op_q == 5'd3 || op_q == 5'd4;
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            op_q  <= 5'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            op_q  <= op_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        op_n    = op_q;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.start) begin
                op_n    = bus.opcode;
                state_n = (bus.opcode == 5'd0 || bus.opcode[4]) ? DONE : LOADA;
            end
            LOADA: begin
                state_n = EXEC;
                cnt_n   = op_q == 5'd3 ? 4'(MUL_CYCLES - 1) : op_q == 5'd4 ? 4'(DIV_CYCLES - 1) : 4'd0;
            end
            EXEC: if (cnt == 4'd0) state_n = WB_LO; else cnt_n = cnt - 4'd1;
            WB_LO: state_n = md ? WB_HI : DONE;
            WB_HI: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.busy    = state != IDLE;
    assign bus.done    = state == DONE;
    assign bus.err     = state == DONE && op_q[4];
    assign bus.Ra_out  = state == LOADA;
    assign bus.Yin     = state == LOADA;
    assign bus.Rb_out  = state == EXEC;
    assign bus.alu_op  = state == EXEC ? op_q : 5'd0;
    assign bus.Zin     = state == EXEC && cnt == 4'd0;
    assign bus.Zlo_out = state == WB_LO;
    assign bus.Rd_in   = state == WB_LO && !md;
    assign bus.LOin    = state == WB_LO && md;
    assign bus.Zhi_out = state == WB_HI;
    assign bus.HIin    = state == WB_HI;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: schedule-based reference model, directed literal checks, random stream
module tb_alu_seq_ctrl;
    localparam int MUL = 2;
    localparam int DIV = 4;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int pass_cnt = 0;
    int total_cnt = 0;
    alu_seq_ctrl_if bus();
    alu_seq_ctrl #(.wordSize(32), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;
    // {busy,done,err, Ra_out,Yin,Rb_out,Zin,Zlo_out,Zhi_out, Rd_in,LOin,HIin, alu_op}
    logic [16:0] dv;
    assign dv = {bus.busy, bus.done, bus.err, bus.Ra_out, bus.Yin, bus.Rb_out, bus.Zin,
                 bus.Zlo_out, bus.Zhi_out, bus.Rd_in, bus.LOin, bus.HIin, bus.alu_op};
    logic [16:0] q[$];
    task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask
    function automatic logic [16:0] vec(bit busy, bit done, bit err, bit ra, bit yin, bit rb, bit zin,
                                        bit zlo, bit zhi, bit rd, bit lo, bit hi, logic [4:0] op);
        return {busy, done, err, ra, yin, rb, zin, zlo, zhi, rd, lo, hi, op};
    endfunction
    // Every accepted operation expands into the exact list of per-cycle outputs it must produce.
    task automatic schedule(logic [4:0] op);
        int n;
        bit m;
        if (op == 0 || op > 15) begin
            q.push_back(vec(1, 1, op > 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            return;
        end
        m = op == 3 || op == 4;
        n = op == 3 ? MUL : op == 4 ? DIV : 1;
        q.push_back(vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < n; i++) q.push_back(vec(1, 0, 0, 0, 0, 1, i == n - 1, 0, 0, 0, 0, 0, op));
        q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, 0, !m, m, 0, 0));
        if (m) q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask
    initial forever begin
        logic [16:0] exp;
        @(posedge clk);
        if (clr) q.delete();
        else if (q.size() > 0) void'(q.pop_front());
        else if (bus.start) schedule(bus.opcode);
        #1;
        exp = q.size() > 0 ? q[0] : 17'd0;
        chk("model", dv, exp);
        total_cnt++;
        if ($countones({bus.Ra_out, bus.Rb_out, bus.Zlo_out, bus.Zhi_out}) <= 1) pass_cnt++;
        else $display("FAIL bus_excl: drivers %b, required at most one high", {bus.Ra_out, bus.Rb_out, bus.Zlo_out, bus.Zhi_out});
    end
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.opcode = 5'd0;
        cyc(3);
        chk("reset_outputs", dv, 17'd0);
        clr = 1'b0;
        cyc(1);
        chk("idle_after_reset", dv, 17'd0);
        bus.start = 1'b1;
        bus.opcode = 5'd1;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            bus.opcode = 5'($urandom_range(16, 31));
            case (c)
                1: chk("add_c1_loada", dv, 17'b1_0_0_1_1_0_0_0_0_0_0_0_00000);
                2: chk("add_c2_exec", dv, 17'b1_0_0_0_0_1_1_0_0_0_0_0_00001);
                3: chk("add_c3_wblo", dv, 17'b1_0_0_0_0_0_0_1_0_1_0_0_00000);
                default: chk("add_c4_done", dv, 17'b1_1_0_0_0_0_0_0_0_0_0_0_00000);
            endcase
        end
        cyc(1);
        chk("add_c5_idle", dv, 17'd0);
        bus.opcode = 5'd6;
        cyc(1);
        chk("b2b_loada", dv, 17'b1_0_0_1_1_0_0_0_0_0_0_0_00000);
        bus.opcode = 5'd2;
        cyc(1);
        chk("b2b_exec_shl", dv, 17'b1_0_0_0_0_1_1_0_0_0_0_0_00110);
        bus.start = 1'b0;
        cyc(4);
        chk("b2b_idle", dv, 17'd0);
        bus.start = 1'b1;
        bus.opcode = 5'd4;
        for (int c = 1; c <= 8; c++) begin
            cyc(1);
            bus.start = 1'b0;
            case (c)
                2: chk("div_c2_exec_nozin", dv[11:10], 2'b10);
                4: chk("div_c4_nozin", dv[10], 1'b0);
                5: chk("div_c5_zin", {dv[11:10], dv[4:0]}, 7'b11_00100);
                6: chk("div_c6_loin", dv[9:5], 5'b10_010);
                7: chk("div_c7_hiin", dv[9:5], 5'b01_001);
                8: chk("div_c8_done", dv[16:14], 3'b110);
                default: ;
            endcase
        end
        cyc(1);
        bus.start = 1'b1;
        bus.opcode = 5'd20;
        cyc(1);
        bus.start = 1'b0;
        chk("illegal_done_err", dv, 17'b1_1_1_0_0_0_0_0_0_0_0_0_00000);
        cyc(1);
        chk("illegal_idle", dv, 17'd0);
        bus.start = 1'b1;
        bus.opcode = 5'd3;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        chk("mul_second_exec", dv, 17'b1_0_0_0_0_1_1_0_0_0_0_0_00011);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        chk("mul_abort_idle", dv, 17'd0);
        for (int c = 0; c < 4; c++) begin
            cyc(1);
            chk("mul_abort_no_wb", dv, 17'd0);
        end
        clr = 1'b1;
        bus.start = 1'b1;
        bus.opcode = 5'd1;
        cyc(1);
        chk("clr_beats_start", dv, 17'd0);
        clr = 1'b0;
        bus.start = 1'b0;
        cyc(1);
        chk("clr_beats_start_idle", dv, 17'd0);
        repeat (3000) begin
            bus.start = $urandom_range(0, 2) == 0;
            bus.opcode = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
            clr = $urandom_range(0, 49) == 0;
            cyc(1);
        end
        bus.start = 1'b0;
        clr = 1'b0;
        cyc(20);
        chk("final_idle", dv, 17'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter wordSize, default 32: datapath word width; only affects documentation of the datapath, not controller ports.
REQ-002 Parameter MUL_CYCLES, default 2, range 1-15: EXEC cycles for mul.
REQ-003 Parameter DIV_CYCLES, default 4, range 1-15: EXEC cycles for div.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request to execute one ALU operation; sampled only in IDLE.
REQ-007 opcode  input  5  ALU opcode; nop=0, add=1, sub=2, mul=3, div=4, shr=5, shl=6, shra=7, ror=8, rol=9, and=10, or=11, neg=12, xor=13, nor=14, not=15.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse at end of an operation.
REQ-010 err  output  1  one-cycle pulse, concurrent with done, for illegal opcode (16-31).
REQ-011 Ra_out  output  1  drive source register A onto bus.
REQ-012 Yin  output  1  latch bus into Y (ALU input A).
REQ-013 Rb_out  output  1  drive source register B onto bus (ALU input B).
REQ-014 alu_op  output  5  opcode presented to the ALU; 0 (nop) outside EXEC.
REQ-015 Zin  output  1  latch 64-bit ALU result into Z.
REQ-016 Zlo_out, Zhi_out  output  1 each  drive Z[31:0] / Z[63:32] onto bus.
REQ-017 Rd_in, LOin, HIin  output  1 each  write bus into destination register / LO / HI.

Function
REQ-018 States: IDLE, LOADA, EXEC, WB_LO, WB_HI, DONE; outputs are Moore, decoded from state and counter only.
REQ-019 IDLE: start=1 captures opcode into op_q; legal non-nop -> LOADA; nop or illegal -> DONE; start=0 -> stay.
REQ-020 LOADA (1 cycle): Ra_out=1, Yin=1 -> EXEC.
REQ-021 EXEC: Rb_out=1, alu_op=op_q; length 1 cycle for all ops except mul (MUL_CYCLES) and div (DIV_CYCLES); 4-bit down-counter loaded on LOADA->EXEC.
REQ-022 Zin=1 only in the last EXEC cycle; then -> WB_LO.
REQ-023 WB_LO (1 cycle): Zlo_out=1; LOin=1 for mul/div, otherwise Rd_in=1; mul/div -> WB_HI, else -> DONE.
REQ-024 WB_HI (1 cycle): Zhi_out=1, HIin=1 -> DONE.
REQ-025 DONE (1 cycle): done=1; err=1 if op_q>15; -> IDLE unconditionally.
REQ-026 Latency from accepting edge to done high: single-cycle ops 4 cycles (LOADA, EXEC, WB_LO, DONE); mul 4+MUL_CYCLES; div 4+DIV_CYCLES; nop/illegal 1.
REQ-027 start and opcode changes while busy are ignored; op_q is stable for the whole operation.
REQ-028 A new start in the cycle after done is accepted (back-to-back, no idle gap required beyond the IDLE cycle).
REQ-029 At most one of Ra_out, Rb_out, Zlo_out, Zhi_out is high in any cycle (single-bus rule).
REQ-030 Illegal opcode never asserts any datapath control (Ra_out..HIin all 0).

Reset
REQ-031 clr=1 at a rising edge forces IDLE, op_q=0, counter=0, regardless of state, including mid-EXEC.
REQ-032 During and after reset all outputs are 0: busy, done, err, all enables, alu_op=0.
REQ-033 clr has priority over start in the same cycle; start is not accepted.
REQ-034 No partial writeback completes after a reset mid-operation (no later Rd_in/LOin/HIin for the aborted op).

Verification
REQ-035 add: start with opcode=1 -> Ra_out+Yin at cycle 1, Rb_out+Zin+alu_op=1 at cycle 2, Zlo_out+Rd_in at cycle 3, done at cycle 4, never HIin.
REQ-036 div, DIV_CYCLES=4: opcode=4 -> EXEC cycles 2-5, Zin only at cycle 5, LOin at 6, HIin at 7, done at 8.
REQ-037 Illegal: opcode=20 -> done=1 and err=1 at cycle 1, all datapath enables 0 throughout.
REQ-038 Reset mid-op: mul accepted, clr=1 in second EXEC cycle -> next cycle IDLE, busy=0, no Zin/LOin/HIin afterwards.
REQ-039 Busy ignore and back-to-back: start held high with opcode toggling during and after an add -> only the captured opcode executes; new op accepted in the IDLE cycle following done.
REQ-040 Bus-exclusivity assertion (REQ-029) checked every cycle over a random opcode/start/clr stream.
